uart_frame_sequencer: RTL and testbench

- Sits between the LFSR snapshot FIFO read port and the UART transmitter.
- Drains FIFO bytes into fixed-length UART frames: sync header byte, FRAME_BYTES payload bytes, optional XOR checksum.
- Owns fifo rdreq and transmitter wr_en; replaces the manual Rdreq/Wr_en switches.
- FIFO read side is clocked by clk_50 in this integration, normal (non-show-ahead) mode.

---
 rtl/uart_frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_uart_frame_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sequencer.sv
// Drains FIFO bytes into UART frames: SYNC_BYTE header, FRAME_BYTES payload bytes and,
// when UART_FRAME_CHECKSUM_EN is defined, a trailing XOR checksum byte.
module uart_frame_sequencer #(
  parameter int         FRAME_BYTES = 8,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         CNT_W       = 16
) (
  input  logic             clk_50,
  input  logic             clr,
  input  logic             enable,
  input  logic             fifo_rdempty,
  input  logic [7:0]       fifo_q,
  output logic             fifo_rdreq,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_wr_en,
  output logic             active,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD,
    ST_RD_WAIT,
    ST_SEND,
    ST_ACK_WAIT,
    ST_DONE_WAIT,
`ifdef UART_FRAME_CHECKSUM_EN
    ST_CHK,
`endif
    ST_FIN
  } state_t;

  localparam logic [7:0]       LAST_IDX = 8'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_rdreq;
  logic [7:0]       r_tx_data;
  logic             r_wr_en;
  logic             r_active;
  logic             r_done;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [7:0]       r_idx;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]       r_chksum;
  logic             r_chk_sent;
`endif

  // NOTE: every register here is state, so all updates are non-blocking; blocking
  // assignments would let later statements see same-edge values and break timing.
  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      r_state     <= ST_IDLE;
      r_rdreq     <= 1'b0;
      r_tx_data   <= 8'h00;
      r_wr_en     <= 1'b0;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
      r_idx       <= 8'h00;
`ifdef UART_FRAME_CHECKSUM_EN
      r_chksum    <= 8'h00;
      r_chk_sent  <= 1'b0;
`endif
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      r_rdreq <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable && !fifo_rdempty && !tx_busy) begin
            r_state  <= ST_HDR;
            r_idx    <= 8'h00;
            r_active <= 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
            r_chksum   <= 8'h00;
            r_chk_sent <= 1'b0;
`endif
          end
        end
        ST_HDR: begin
          r_tx_data <= SYNC_BYTE;
          r_wr_en   <= 1'b1;
          r_state   <= ST_ACK_WAIT;
        end
        ST_RD: begin
          if (!fifo_rdempty) begin
            r_rdreq <= 1'b1;
            r_state <= ST_RD_WAIT;
          end
        end
        // The FIFO registers the read on the edge leaving RD_WAIT; fifo_q is then
        // valid while in SEND and is captured together with raising tx_wr_en.
        ST_RD_WAIT: r_state <= ST_SEND;
        ST_SEND: begin
          r_tx_data <= fifo_q;
          r_idx     <= r_idx + 8'd1;
`ifdef UART_FRAME_CHECKSUM_EN
          r_chksum  <= r_chksum ^ fifo_q;
`endif
          r_wr_en   <= 1'b1;
          r_state   <= ST_ACK_WAIT;
        end
        ST_ACK_WAIT: begin
          if (tx_busy) begin
            r_wr_en <= 1'b0;
            r_state <= ST_DONE_WAIT;
          end
        end
        ST_DONE_WAIT: begin
          if (!tx_busy) begin
`ifdef UART_FRAME_CHECKSUM_EN
            if (r_chk_sent)             r_state <= ST_FIN;
            else if (r_idx < LAST_IDX)  r_state <= ST_RD;
            else                        r_state <= ST_CHK;
`else
            if (r_idx < LAST_IDX)       r_state <= ST_RD;
            else                        r_state <= ST_FIN;
`endif
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        ST_CHK: begin
          r_tx_data  <= r_chksum;
          r_wr_en    <= 1'b1;
          r_chk_sent <= 1'b1;
          r_state    <= ST_ACK_WAIT;
        end
`endif
        ST_FIN: begin
          r_done      <= 1'b1;
          r_frame_cnt <= r_frame_cnt + CNT_ONE;
          r_active    <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_rdreq = r_rdreq;
  assign tx_data    = r_tx_data;
  assign tx_wr_en   = r_wr_en;
  assign active     = r_active;
  assign frame_done = r_done;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Bench for uart_frame_sequencer: FIFO and transmitter models, a frame-level byte
// scoreboard and protocol checks evaluated every cycle on the falling clock edge.
module tb_uart_frame_sequencer;

  localparam int FB = 8;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = FB + 2;
`else
  localparam int FRAME_LEN = FB + 1;
`endif

  logic        clk_50 = 1'b0;
  logic        clr = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_rdempty;
  logic [7:0]  fifo_q = 8'h00;
  logic        fifo_rdreq;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_wr_en;
  logic        active;
  logic        frame_done;
  logic [15:0] frame_cnt;

  uart_frame_sequencer #(.FRAME_BYTES(FB), .SYNC_BYTE(8'hA5), .CNT_W(16)) dut (
    .clk_50(clk_50), .clr(clr), .enable(enable), .fifo_rdempty(fifo_rdempty),
    .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq), .tx_busy(tx_busy), .tx_data(tx_data),
    .tx_wr_en(tx_wr_en), .active(active), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #10 clk_50 = ~clk_50;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Non-show-ahead FIFO: q updates on the edge that samples rdreq.
  logic [7:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_rdempty = (wr_ptr == rd_ptr);

  always @(posedge clk_50) begin
    if (fifo_rdreq && (wr_ptr != rd_ptr)) begin
      fifo_q <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic fifo_push8(input logic [7:0] b [8]);
    for (int i = 0; i < 8; i++) begin
      fifo_mem[wr_ptr] = b[i];
      wr_ptr++;
    end
  endtask

  // Transmitter: accepts acc_delay+1 cycles after seeing wr_en, then busy 20 cycles.
  int acc_delay = 0;
  int wcnt = 0;
  int bcnt = 0;
  always @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      tx_busy <= 1'b0;
      wcnt = 0;
      bcnt = 0;
    end else if (tx_busy) begin
      if (bcnt == 1) tx_busy <= 1'b0;
      bcnt = bcnt - 1;
    end else if (tx_wr_en) begin
      if (wcnt == acc_delay) begin
        tx_busy <= 1'b1;
        bcnt = 20;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  // Frame model: header, payload, optional XOR of payload.
  logic [7:0] exp_q [$];
  logic [7:0] sent_q [$];

  task automatic add_frame(input logic [7:0] b [8]);
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      x = x ^ b[i];
    end
`ifdef UART_FRAME_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  logic        prev_wr = 1'b0, prev_busy = 1'b0, prev_done = 1'b0, prev_rdreq = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        pending = 1'b0;
  logic [15:0] model_cnt = 16'h0000;
  int acc_in_frame = 0, frames_seen = 0, rdreq_cnt = 0, wr_len = 0, last_wr_len = 0;

  always @(negedge clk_50) begin
    if (!clr) begin
      acc_in_frame = 0;
      pending      = 1'b0;
      model_cnt    = 16'h0000;
      wr_len       = 0;
      prev_wr      = 1'b0;
      prev_busy    = 1'b0;
      prev_done    = 1'b0;
      prev_rdreq   = 1'b0;
      prev_data    = 8'h00;
    end else begin
      if (fifo_rdreq) begin
        rdreq_cnt++;
        check("rdreq_while_empty", fifo_rdempty, 0);
        check("rdreq_width", prev_rdreq, 0);
      end
      if (prev_wr) check("wr_en_hold", tx_wr_en, !prev_busy);
      if ((prev_wr || prev_busy) && (tx_wr_en || tx_busy))
        check("tx_data_stable", tx_data, prev_data);
      if (tx_wr_en) wr_len++;
      else if (prev_wr) begin
        last_wr_len = wr_len;
        wr_len = 0;
      end
      if (tx_busy && !prev_busy) begin
        sent_q.push_back(tx_data);
        check("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("tx_byte", tx_data, exp_q.pop_front());
        check("active_during_tx", active, 1);
        acc_in_frame++;
        if (acc_in_frame == FRAME_LEN) begin
          acc_in_frame = 0;
          pending = 1'b1;
          model_cnt = model_cnt + 16'd1;
        end
      end
      if (frame_done) begin
        frames_seen++;
        check("done_expected", pending, 1);
        pending = 1'b0;
        check("frame_cnt_at_done", frame_cnt, model_cnt);
        check("active_at_done", active, 0);
        check("done_width", prev_done, 0);
      end
      prev_wr    = tx_wr_en;
      prev_busy  = tx_busy;
      prev_done  = frame_done;
      prev_rdreq = fifo_rdreq;
      prev_data  = tx_data;
    end
  end

  task automatic wait_frames(input int n, input string name);
    int k;
    k = 0;
    while (frames_seen < n && k < 3000) begin
      @(negedge clk_50);
      k++;
    end
    check(name, frames_seen, n);
  endtask

  task automatic wait_accepts(input int n, input string name);
    int k;
    k = 0;
    while (acc_in_frame != n && k < 3000) begin
      @(negedge clk_50);
      k++;
    end
    check(name, acc_in_frame, n);
  endtask

  logic [7:0] f1 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
  logic [7:0] f2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] f3 [8] = '{8'hF0, 8'h0F, 8'h5A, 8'hC3, 8'h81, 8'h7E, 8'h00, 8'hFF};
  logic [7:0] f4 [8] = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98};
  logic [7:0] f5 [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
  logic [7:0] f6 [8] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset and idle with data waiting but enable low.
    fifo_push8(f1);
    #15;
    check("rst_wr_en", tx_wr_en, 0);
    check("rst_rdreq", fifo_rdreq, 0);
    check("rst_active", active, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk_50);
    clr = 1'b1;
    repeat (50) @(negedge clk_50);
    check("idle_rdreq_cnt", rdreq_cnt, 0);
    check("idle_active", active, 0);
    check("idle_wr_en", tx_wr_en, 0);
    check("idle_frame_cnt", frame_cnt, 0);

    // Single frame 01..08.
    add_frame(f1);
    enable = 1'b1;
    wait_frames(1, "single_frame_done");
    check("single_frame_cnt", frame_cnt, 1);
    check("single_rdreq_cnt", rdreq_cnt, 8);
    check("single_len", sent_q.size(), FRAME_LEN);
    check("single_hdr", sent_q[0], 8'hA5);
    check("single_b1", sent_q[1], 8'h01);
    check("single_b8", sent_q[8], 8'h08);
`ifdef UART_FRAME_CHECKSUM_EN
    check("single_chk", sent_q[9], 8'h08);
`endif
    check("single_wr_len", last_wr_len, 2);

    // Underflow: 3 bytes, stall, then the remaining 5.
    add_frame(f2);
    for (int i = 0; i < 3; i++) begin
      fifo_mem[wr_ptr] = f2[i];
      wr_ptr++;
    end
    repeat (500) @(negedge clk_50);
    check("stall_rdreq_cnt", rdreq_cnt, 11);
    check("stall_active", active, 1);
    check("stall_sent", sent_q.size(), FRAME_LEN + 4);
    for (int i = 3; i < 8; i++) begin
      fifo_mem[wr_ptr] = f2[i];
      wr_ptr++;
    end
    wait_frames(2, "stall_frame_done");
    check("stall_frame_cnt", frame_cnt, 2);
    check("stall_rdreq_total", rdreq_cnt, 16);
    check("stall_no_extra_hdr", sent_q[FRAME_LEN + 4], 8'h44);
`ifdef UART_FRAME_CHECKSUM_EN
    check("stall_chk", sent_q[2 * FRAME_LEN - 1], 8'h88);
`endif

    // Handshake hold: busy rises 7 cycles after wr_en.
    acc_delay = 6;
    add_frame(f3);
    fifo_push8(f3);
    wait_frames(3, "hold_frame_done");
    check("hold_wr_len", last_wr_len, 8);
    check("hold_frame_cnt", frame_cnt, 3);

    // Enable drop after the 3rd payload byte with 16 bytes queued.
    acc_delay = 0;
    add_frame(f4);
    fifo_push8(f4);
    fifo_push8(f5);
    wait_accepts(4, "drop_reach_b3");
    enable = 1'b0;
    wait_frames(4, "drop_frame_done");
    repeat (300) @(negedge clk_50);
    check("drop_frame_cnt", frame_cnt, 4);
    check("drop_rdreq_cnt", rdreq_cnt, 32);
    check("drop_active", active, 0);
    check("drop_fifo_left", wr_ptr - rd_ptr, 8);

    // Counter wrap from 0xFFFF.
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk_50);
    release dut.r_frame_cnt;
    model_cnt = 16'hFFFF;
    @(negedge clk_50);
    check("wrap_preload", frame_cnt, 16'hFFFF);
    add_frame(f5);
    enable = 1'b1;
    wait_frames(5, "wrap_frame_done");
    check("wrap_frame_cnt", frame_cnt, 0);
    check("wrap_rdreq_cnt", rdreq_cnt, 40);

    // Reset while the 4th byte is being offered.
    acc_delay = 6;
    add_frame(f6);
    fifo_push8(f6);
    wait_accepts(3, "rst_reach_b2");
    for (int k = 0; k < 100 && !tx_wr_en; k++) @(negedge clk_50);
    check("rst_4th_offered", tx_wr_en, 1);
    #3;
    clr = 1'b0;
    #1;
    check("async_wr_en", tx_wr_en, 0);
    check("async_active", active, 0);
    check("async_tx_data", tx_data, 0);
    check("async_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    enable = 1'b0;
    repeat (3) @(negedge clk_50);
    clr = 1'b1;
    repeat (20) @(negedge clk_50);
    check("post_rst_active", active, 0);
    check("post_rst_wr_en", tx_wr_en, 0);
    check("post_rst_rdreq_cnt", rdreq_cnt, 43);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
